// File: rtl/apb_master_bridge.sv
// Purpose: APB4 requester turning single command-port requests into one APB read/write transfer each.
// Latency: accept N, SETUP N+1, ACCESS N+2.., rsp_valid_o one cycle after pready_i, ready again next cycle.
// Backpressure: cmd_ready_o is high only in IDLE (one outstanding transfer); responses cannot be stalled.
//
// Ports:
//   clk, reset_n         clock (rising edge) and asynchronous active-low reset
//   cmd_*                command request (valid/ready handshake), write flag, address, data, strobes
//   rsp_*                one-cycle response strobe plus held read data / error / timeout status
//   p*_o, p*_i           APB4 requester signals
module apb_master_bridge #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_write_i,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [DATA_W-1:0]   cmd_wdata_i,
  input  logic [DATA_W/8-1:0] cmd_strb_i,
  output logic                rsp_valid_o,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_error_o,
  output logic                rsp_timeout_o,
  output logic                psel_o,
  output logic                penable_o,
  output logic                pwrite_o,
  output logic [ADDR_W-1:0]   paddr_o,
  output logic [DATA_W-1:0]   pwdata_o,
  output logic [DATA_W/8-1:0] pstrb_o,
  input  logic                pready_i,
  input  logic [DATA_W-1:0]   prdata_i,
  input  logic                pslverr_i
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                timeout_hit;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic [STRB_W-1:0]   pstrb_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_error_q;
  logic                rsp_timeout_q;

  // Counter holds the number of ACCESS cycles already spent waiting, so the
  // abort fires on the TIMEOUT_CYCLES-th ACCESS cycle.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid_i) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready_i || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: handshake and APB control are pure state decodes so an
  // asynchronous reset drops them immediately.
  always_comb begin
    cmd_ready_o = 1'b0;
    psel_o      = 1'b0;
    penable_o   = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_q)
      IDLE:    cmd_ready_o = 1'b1;
      SETUP:   psel_o      = 1'b1;
      ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
      end
      RESP:    rsp_valid_o = 1'b1;
      default: cmd_ready_o = 1'b0;
    endcase
  end

  // Wait-state counter; saturates so a disabled timeout never wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (state_q == SETUP) begin
      cnt_q <= '0;
    end else if (state_q == ACCESS && !pready_i && cnt_q != '1) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Command capture. Address is word aligned; reads carry zero data and
  // zero strobes. Payload holds its value until the next accepted command.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
    end else if (state_q == IDLE && cmd_valid_i) begin
      pwrite_q <= cmd_write_i;
      paddr_q  <= cmd_addr_i & ~ADDR_W'(3);
      pwdata_q <= cmd_write_i ? cmd_wdata_i : '0;
      pstrb_q  <= cmd_write_i ? cmd_strb_i  : '0;
    end
  end

  // Response capture at the end of ACCESS. Read data is only returned for
  // successful reads; pslverr_i/prdata_i are ignored during wait states.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else if (state_q == ACCESS) begin
      if (pready_i) begin
        rsp_rdata_q   <= (!pwrite_q && !pslverr_i) ? prdata_i : '0;
        rsp_error_q   <= pslverr_i;
        rsp_timeout_q <= 1'b0;
      end else if (timeout_hit) begin
        rsp_rdata_q   <= '0;
        rsp_error_q   <= 1'b1;
        rsp_timeout_q <= 1'b1;
      end
    end
  end

  assign pwrite_o      = pwrite_q;
  assign paddr_o       = paddr_q;
  assign pwdata_o      = pwdata_q;
  assign pstrb_o       = pstrb_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_error_o   = rsp_error_q;
  assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Purpose: directed self-checking bench for apb_master_bridge.
// Latency: inputs driven and outputs sampled on the falling edge, half a cycle from the active edge.
// Backpressure: command handshake observed through cmd_ready_o; pready_i wait states driven per scenario.
module tb_apb_master_bridge;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cmd_valid_i = 1'b0;
  logic              cmd_ready_o;
  logic              cmd_write_i = 1'b0;
  logic [ADDR_W-1:0] cmd_addr_i = '0;
  logic [DATA_W-1:0] cmd_wdata_i = '0;
  logic [STRB_W-1:0] cmd_strb_i = '0;
  logic              rsp_valid_o;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_error_o;
  logic              rsp_timeout_o;
  logic              psel_o;
  logic              penable_o;
  logic              pwrite_o;
  logic [ADDR_W-1:0] paddr_o;
  logic [DATA_W-1:0] pwdata_o;
  logic [STRB_W-1:0] pstrb_o;
  logic              pready_i = 1'b0;
  logic [DATA_W-1:0] prdata_i = '0;
  logic              pslverr_i = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_master_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_strb_i(cmd_strb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_error_o(rsp_error_o),
    .rsp_timeout_o(rsp_timeout_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o), .paddr_o(paddr_o),
    .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .pready_i(pready_i), .prdata_i(prdata_i), .pslverr_i(pslverr_i)
  );

  task automatic drive_cmd(input logic wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
    cmd_valid_i = 1'b1;
    cmd_write_i = wr;
    cmd_addr_i  = a;
    cmd_wdata_i = d;
    cmd_strb_i  = s;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #12;
    checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %0b exp 1", cmd_ready_o); end
    checks++; if ({psel_o, penable_o, pwrite_o} !== 3'b000) begin errors++; $display("FAIL reset_apb_ctl got %b exp 000", {psel_o, penable_o, pwrite_o}); end
    checks++; if ({paddr_o, pwdata_o, pstrb_o} !== '0) begin errors++; $display("FAIL reset_apb_payload got %h/%h/%h exp 0", paddr_o, pwdata_o, pstrb_o); end
    checks++; if ({rsp_valid_o, rsp_error_o, rsp_timeout_o} !== 3'b000) begin errors++; $display("FAIL reset_rsp_flags got %b exp 000", {rsp_valid_o, rsp_error_o, rsp_timeout_o}); end
    checks++; if (rsp_rdata_o !== '0) begin errors++; $display("FAIL reset_rsp_rdata got %h exp 0", rsp_rdata_o); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready_o !== 1'b1 || psel_o !== 1'b0) begin errors++; $display("FAIL post_reset_idle got ready=%0b psel=%0b exp 1/0", cmd_ready_o, psel_o); end
  endtask

  task automatic test_write;
    @(negedge clk);
    drive_cmd(1'b1, 12'h008, 32'h0000_001B, 4'hF);
    pready_i = 1'b1;
    checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL wr_accept_ready got %0b exp 1", cmd_ready_o); end
    @(negedge clk);
    cmd_valid_i = 1'b0;
    cmd_wdata_i = 32'hFFFF_FFFF;
    checks++; if ({psel_o, penable_o, cmd_ready_o} !== 3'b100) begin errors++; $display("FAIL wr_setup_ctl got %b exp 100", {psel_o, penable_o, cmd_ready_o}); end
    checks++; if (paddr_o !== 12'h008 || pwrite_o !== 1'b1 || pstrb_o !== 4'hF || pwdata_o !== 32'h1B) begin errors++; $display("FAIL wr_setup_payload got %h/%0b/%h/%h exp 008/1/f/0000001b", paddr_o, pwrite_o, pstrb_o, pwdata_o); end
    @(negedge clk);
    checks++; if ({psel_o, penable_o} !== 2'b11) begin errors++; $display("FAIL wr_access_ctl got %b exp 11", {psel_o, penable_o}); end
    checks++; if (paddr_o !== 12'h008 || pwrite_o !== 1'b1 || pstrb_o !== 4'hF || pwdata_o !== 32'h1B) begin errors++; $display("FAIL wr_access_payload got %h/%0b/%h/%h exp 008/1/f/0000001b", paddr_o, pwrite_o, pstrb_o, pwdata_o); end
    @(negedge clk);
    pready_i = 1'b0;
    checks++; if ({rsp_valid_o, rsp_error_o, rsp_timeout_o, psel_o} !== 4'b1000) begin errors++; $display("FAIL wr_resp_flags got %b exp 1000", {rsp_valid_o, rsp_error_o, rsp_timeout_o, psel_o}); end
    checks++; if (rsp_rdata_o !== '0) begin errors++; $display("FAIL wr_resp_rdata got %h exp 0", rsp_rdata_o); end
    @(negedge clk);
    checks++; if ({rsp_valid_o, cmd_ready_o} !== 2'b01 || paddr_o !== 12'h008) begin errors++; $display("FAIL wr_after_resp got valid=%0b ready=%0b paddr=%h exp 0/1/008", rsp_valid_o, cmd_ready_o, paddr_o); end
  endtask

  task automatic test_read_wait;
    @(negedge clk);
    drive_cmd(1'b0, 12'h013, 32'hAAAA_AAAA, 4'hF);
    pready_i = 1'b0;
    prdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    checks++; if ({psel_o, penable_o} !== 2'b10 || paddr_o !== 12'h010 || pstrb_o !== 4'h0 || pwdata_o !== '0 || pwrite_o !== 1'b0) begin errors++; $display("FAIL rd_setup got sel/en=%b paddr=%h strb=%h wdata=%h wr=%0b exp 10/010/0/0/0", {psel_o, penable_o}, paddr_o, pstrb_o, pwdata_o, pwrite_o); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ({psel_o, penable_o} !== 2'b11 || paddr_o !== 12'h010 || pstrb_o !== 4'h0 || rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rd_wait%0d got sel/en=%b paddr=%h strb=%h rv=%0b exp 11/010/0/0", i, {psel_o, penable_o}, paddr_o, pstrb_o, rsp_valid_o); end
    end
    @(negedge clk);
    checks++; if ({psel_o, penable_o} !== 2'b11) begin errors++; $display("FAIL rd_ready_cycle got %b exp 11", {psel_o, penable_o}); end
    pready_i = 1'b1;
    prdata_i = 32'h0000_0005;
    @(negedge clk);
    pready_i = 1'b0;
    prdata_i = 32'h0;
    checks++; if ({rsp_valid_o, rsp_error_o, rsp_timeout_o} !== 3'b100 || rsp_rdata_o !== 32'h5) begin errors++; $display("FAIL rd_resp got flags=%b rdata=%h exp 100/00000005", {rsp_valid_o, rsp_error_o, rsp_timeout_o}, rsp_rdata_o); end
    @(negedge clk);
    checks++; if (rsp_valid_o !== 1'b0 || rsp_rdata_o !== 32'h5) begin errors++; $display("FAIL rd_rsp_hold got valid=%0b rdata=%h exp 0/00000005", rsp_valid_o, rsp_rdata_o); end
  endtask

  task automatic test_slverr;
    @(negedge clk);
    drive_cmd(1'b1, 12'h020, 32'h0000_0055, 4'h3);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    @(negedge clk);
    pslverr_i = 1'b1;
    @(negedge clk);
    pslverr_i = 1'b0;
    checks++; if ({psel_o, penable_o} !== 2'b11) begin errors++; $display("FAIL err_wait_ignored got %b exp 11", {psel_o, penable_o}); end
    @(negedge clk);
    pready_i = 1'b1;
    pslverr_i = 1'b1;
    @(negedge clk);
    pready_i = 1'b0;
    pslverr_i = 1'b0;
    checks++; if ({rsp_valid_o, rsp_error_o, rsp_timeout_o} !== 3'b110 || rsp_rdata_o !== '0) begin errors++; $display("FAIL err_write_resp got flags=%b rdata=%h exp 110/0", {rsp_valid_o, rsp_error_o, rsp_timeout_o}, rsp_rdata_o); end
    @(negedge clk);
    drive_cmd(1'b0, 12'h030, 32'h0, 4'hF);
    pready_i = 1'b1;
    pslverr_i = 1'b1;
    prdata_i = 32'h0000_1234;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    pready_i = 1'b0;
    pslverr_i = 1'b0;
    prdata_i = 32'h0;
    checks++; if ({rsp_valid_o, rsp_error_o, rsp_timeout_o} !== 3'b110 || rsp_rdata_o !== '0) begin errors++; $display("FAIL err_read_resp got flags=%b rdata=%h exp 110/0", {rsp_valid_o, rsp_error_o, rsp_timeout_o}, rsp_rdata_o); end
  endtask

  task automatic test_timeout;
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    @(negedge clk);
    drive_cmd(1'b0, 12'h040, 32'h0, 4'hF);
    pready_i = 1'b0;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (psel_o && penable_o) n++;
      else done = 1'b1;
    end
    checks++; if (done !== 1'b1 || n != 16) begin errors++; $display("FAIL to_access_cycles got %0d (ended=%0b) exp 16", n, done); end
    checks++; if ({rsp_valid_o, rsp_error_o, rsp_timeout_o, psel_o, penable_o} !== 5'b11100 || rsp_rdata_o !== '0) begin errors++; $display("FAIL to_resp got flags=%b rdata=%h exp 11100/0", {rsp_valid_o, rsp_error_o, rsp_timeout_o, psel_o, penable_o}, rsp_rdata_o); end
    @(negedge clk);
    checks++; if ({cmd_ready_o, rsp_valid_o, psel_o} !== 3'b100) begin errors++; $display("FAIL to_back_idle got %b exp 100", {cmd_ready_o, rsp_valid_o, psel_o}); end
  endtask

  task automatic test_back_to_back;
    logic [ADDR_W-1:0] exp_addr [3];
    logic [DATA_W-1:0] exp_data [3];
    int idx, setups, rsps, accepts, last_setup;
    bit acc_pend;
    exp_addr[0] = 12'h100; exp_addr[1] = 12'h104; exp_addr[2] = 12'h108;
    exp_data[0] = 32'h11;  exp_data[1] = 32'h22;  exp_data[2] = 32'h33;
    idx = 0; setups = 0; rsps = 0; accepts = 0; last_setup = 0; acc_pend = 1'b0;
    @(negedge clk);
    pready_i = 1'b1;
    drive_cmd(1'b1, exp_addr[0], exp_data[0], 4'hF);
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (psel_o && !penable_o) begin
        if (setups < 3) begin
          checks++; if (paddr_o !== exp_addr[setups] || pwdata_o !== exp_data[setups]) begin errors++; $display("FAIL b2b_payload%0d got %h/%h exp %h/%h", setups, paddr_o, pwdata_o, exp_addr[setups], exp_data[setups]); end
        end
        if (setups > 0) begin
          checks++; if (cyc - last_setup != 4) begin errors++; $display("FAIL b2b_spacing%0d got %0d exp 4", setups, cyc - last_setup); end
        end
        last_setup = cyc;
        setups++;
      end
      if (rsp_valid_o) rsps++;
      if (acc_pend) begin
        idx++;
        acc_pend = 1'b0;
        if (idx < 3) drive_cmd(1'b1, exp_addr[idx], exp_data[idx], 4'hF);
        else cmd_valid_i = 1'b0;
      end
      if (cmd_valid_i && cmd_ready_o) begin
        acc_pend = 1'b1;
        accepts++;
      end
    end
    pready_i = 1'b0;
    checks++; if (setups != 3 || accepts != 3 || rsps != 3) begin errors++; $display("FAIL b2b_counts got setups=%0d accepts=%0d rsps=%0d exp 3/3/3", setups, accepts, rsps); end
  endtask

  task automatic test_reset_mid;
    int seen;
    seen = 0;
    @(negedge clk);
    drive_cmd(1'b0, 12'h050, 32'h0, 4'hF);
    pready_i = 1'b0;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    @(negedge clk);
    checks++; if ({psel_o, penable_o} !== 2'b11) begin errors++; $display("FAIL mid_in_access got %b exp 11", {psel_o, penable_o}); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if ({psel_o, penable_o, cmd_ready_o} !== 3'b001) begin errors++; $display("FAIL mid_async_drop got %b exp 001", {psel_o, penable_o, cmd_ready_o}); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid_o) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL mid_no_rsp got %0d strobes exp 0", seen); end
    reset_n = 1'b1;
    drive_cmd(1'b1, 12'h060, 32'h77, 4'hF);
    pready_i = 1'b1;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    checks++; if ({psel_o, penable_o} !== 2'b10 || paddr_o !== 12'h060) begin errors++; $display("FAIL mid_next_setup got %b paddr=%h exp 10/060", {psel_o, penable_o}, paddr_o); end
    @(negedge clk);
    @(negedge clk);
    pready_i = 1'b0;
    checks++; if ({rsp_valid_o, rsp_error_o, rsp_timeout_o} !== 3'b100) begin errors++; $display("FAIL mid_next_resp got %b exp 100", {rsp_valid_o, rsp_error_o, rsp_timeout_o}); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
